// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one operand bit per clock, LSB first,
// and publishes sum, carry-out and signed overflow together when the last bit is done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             carry_nxt;

    // Operands shift right each RUN cycle, so bit 0 is always the bit in progress.
    assign bit_s     = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    // NOTE: every signal gets its default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + ~borrow, so invert b and the carry seed here.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_nxt;
                acc_d = {bit_s, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // c_q here is the carry into the MSB; carry_nxt is the carry out of it.
                    sum_d   = {bit_s, acc_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
                    ovf_d   = c_q ^ carry_nxt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH = 8): arithmetic reference model compared
// every cycle, plus directed operations with hand-computed literal results.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_pass  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference arithmetic: {overflow, cout, sum} from plain integer math.
    function automatic logic [WIDTH+1:0] model_calc(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                                    input logic fcin, input logic fsub);
        logic [WIDTH-1:0] bb;
        logic             cc;
        logic [WIDTH:0]   full;
        int               sa, sb, ssum;
        logic             ov;
        bb   = fsub ? ~fb : fb;
        cc   = fsub ? ~fcin : fcin;
        full = {1'b0, fa} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
        sa   = $signed(fa);
        sb   = $signed(bb);
        ssum = sa + sb + int'(cc);
        ov   = (ssum > 127) || (ssum < -128);
        return {ov, full};
    endfunction

    // Cycle model: an op occupies WIDTH busy cycles, then one done cycle with the new result.
    int               m_left = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;
    logic [WIDTH+1:0] m_pend = '0;
    logic             model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left      <= 0;
            m_done      <= 1'b0;
            m_sum       <= '0;
            m_cout      <= 1'b0;
            m_ovf       <= 1'b0;
            model_valid <= 1'b1;
        end else if (start && m_left == 0) begin
            m_left <= WIDTH;
            m_done <= 1'b0;
            m_pend <= model_calc(a, b, cin, sub);
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                {m_ovf, m_cout, m_sum} <= m_pend;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_busy", 64'(busy), 64'(m_left != 0));
            check("model_done", 64'(done), 64'(m_done));
            check("model_sum",  64'(sum),  64'(m_sum));
            check("model_cout", 64'(cout), 64'(m_cout));
            check("model_ovf",  64'(overflow), 64'(m_ovf));
        end
    end

    task automatic drive_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                               input logic tcin, input logic tsub);
        a     = ta;
        b     = tb_;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
    endtask

    // Called right after the acceptance edge's following negedge; counts cycles until done.
    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_timeout"}, 64'(cyc < 20), 64'(1));
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        int cyc;
        drive_start(ta, tb_, tcin, tsub);
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_;
        wait_done(name, cyc);
        check({name, "_latency"}, 64'(cyc), 64'(WIDTH));
        check({name, "_sum"},  64'(sum), 64'(exp_sum));
        check({name, "_cout"}, 64'(cout), 64'(exp_cout));
        check({name, "_ovf"},  64'(overflow), 64'(exp_ovf));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int n_done;

        rst = 1'b1;
        drive_start(8'hAA, 8'h55, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_sum",  64'(sum),  64'(0));
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start re-asserted during RUN with different operands must be ignored.
        drive_start(8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        drive_start(8'hFF, 8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                n_done++;
                check("ignore_sum", 64'(sum), 64'(8'h30));
            end
            @(negedge clk);
        end
        check("ignore_done_count", 64'(n_done), 64'(1));

        // Reset during RUN aborts without a done pulse.
        drive_start(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sum",  64'(sum),  64'(0));
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));
        run_op("after_abort", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0);

        // Back-to-back: op 2 launched in op 1's done cycle.
        drive_start(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_op1", cyc);
        check("b2b_op1_sum", 64'(sum), 64'(8'h02));
        drive_start(8'h03, 8'h04, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", 64'(busy), 64'(1));
        check("b2b_done_fall", 64'(done), 64'(0));
        wait_done("b2b_op2", cyc);
        check("b2b_gap", 64'(cyc), 64'(WIDTH));
        check("b2b_op2_sum", 64'(sum), 64'(8'h07));
        repeat (3) @(negedge clk);
        check("idle_hold_sum", 64'(sum), 64'(8'h07));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
